// File: rtl/ram_block_be.sv
// -----------------------------------------------------------------------------
// ram_block_be
//   Single-port word RAM with per-byte write enables. It has a selectable
//   read-during-write result, an optional output register, and a clear
//   sequencer that zeroes every word after reset or on request. A busy flag
//   and a read-valid strobe let the CPU memory FSM work without assuming a
//   fixed latency.
//
// Ports
//   clka     : clock, rising edge
//   rstn     : synchronous active-low reset
//   ena      : access enable (taken only while not busy)
//   wea      : byte write enables, bit i covers dina[8i+7:8i]; all zero = read
//   addra    : word address
//   dina     : write data
//   clr      : one-cycle request to start a clear sequence
//   douta    : access result (holds its value between results)
//   rd_valid : one-cycle strobe, douta carries a new result
//   busy     : clear sequence running, accesses are ignored
// -----------------------------------------------------------------------------
module ram_block_be #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 11,
    parameter int DEPTH          = 2048,
    parameter int OUT_REG        = 0,
    parameter int WR_MODE        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clka,
    input  logic                  rstn,
    input  logic                  ena,
    input  logic [DATA_W/8-1:0]   wea,
    input  logic [ADDR_W-1:0]     addra,
    input  logic [DATA_W-1:0]     dina,
    input  logic                  clr,
    output logic [DATA_W-1:0]     douta,
    output logic                  rd_valid,
    output logic                  busy
);

    localparam int NB = DATA_W / 8;
    // DEPTH may equal 2**ADDR_W, so the range compare needs one extra bit.
    localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state, state_nxt;
    logic                clr_pend;      // clear owed after reset release
    logic [ADDR_W-1:0]   clr_ptr;
    logic                clr_last;

    logic                accept;
    logic                in_range;
    logic                wr_acc;
    logic [ADDR_W-1:0]   rd_idx;
    logic [DATA_W-1:0]   wmask;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   raw_q;         // synchronous read port output

    // Stage 1: control that travels alongside the memory read.
    logic                v1;
    logic                in1;
    logic [DATA_W-1:0]   wdat1;
    logic [DATA_W-1:0]   wmask1;
    logic [DATA_W-1:0]   res1;

    logic                fin_v;
    logic [DATA_W-1:0]   fin_d;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    assign clr_last = (clr_ptr == LAST_PTR);

    // NOTE: state and counters use non-blocking assignments so every
    // register samples the values from before the edge, independent of the
    // order in which the always blocks run.
    always_ff @(posedge clka) begin
        if (!rstn) begin
            state    <= IDLE;
            clr_ptr  <= '0;
            clr_pend <= (CLEAR_ON_RESET != 0);
        end else begin
            state    <= state_nxt;
            clr_pend <= 1'b0;
            if (state == CLEAR)
                clr_ptr <= clr_last ? '0 : clr_ptr + 1'b1;
        end
    end

    // NOTE: next state gets a default before the case so no path leaves it
    // unassigned; otherwise a latch would be inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr_pend || clr) state_nxt = CLEAR;
            CLEAR:   if (clr_last)        state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Gated by rstn so busy drops as soon as reset is asserted.
    assign busy = rstn && (state == CLEAR);

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    assign accept   = ena && rstn && (state == IDLE);
    assign in_range = ({1'b0, addra} < DEPTH_V);
    assign wr_acc   = accept && in_range && (|wea);
    assign rd_idx   = in_range ? addra : '0;

    always_comb begin
        wmask = '0;
        for (int b = 0; b < NB; b++)
            wmask[8*b +: 8] = {8{wea[b]}};
    end

    // ------------------------------------------------------------------
    // Storage: one write port shared by the clear sequencer and accesses,
    // and one synchronous read port.
    // ------------------------------------------------------------------
    // NOTE: the array has no reset. Resetting it would prevent block RAM
    // inference, and its contents must survive reset anyway.
    always_ff @(posedge clka) begin
        if (busy) begin
            mem[clr_ptr] <= '0;
        end else if (wr_acc) begin
            for (int b = 0; b < NB; b++)
                if (wea[b]) mem[addra][8*b +: 8] <= dina[8*b +: 8];
        end
    end

    // This read sees the pre-write word on a same-cycle write (read-first).
    // The write-first result is rebuilt in stage 1 from the captured data.
    always_ff @(posedge clka) begin
        if (!rstn)
            raw_q <= '0;
        else if (accept)
            raw_q <= mem[rd_idx];
    end

    always_ff @(posedge clka) begin
        if (!rstn) begin
            v1     <= 1'b0;
            in1    <= 1'b0;
            wdat1  <= '0;
            wmask1 <= '0;
        end else begin
            v1 <= accept;
            if (accept) begin
                in1    <= in_range;
                wdat1  <= dina;
                wmask1 <= wmask;
            end
        end
    end

    always_comb begin
        res1 = '0;
        if (in1)
            res1 = (WR_MODE != 0) ? ((raw_q & ~wmask1) | (wdat1 & wmask1)) : raw_q;
    end

    // ------------------------------------------------------------------
    // Optional extra register stage
    // ------------------------------------------------------------------
    if (OUT_REG != 0) begin : g_oreg
        logic              v2;
        logic [DATA_W-1:0] d2;

        always_ff @(posedge clka) begin
            if (!rstn) begin
                v2 <= 1'b0;
                d2 <= '0;
            end else begin
                v2 <= v1;
                if (v1) d2 <= res1;
            end
        end

        assign fin_v = v2;
        assign fin_d = d2;
    end else begin : g_noreg
        assign fin_v = v1;
        assign fin_d = res1;
    end

    // ------------------------------------------------------------------
    // Output hold register
    // ------------------------------------------------------------------
    always_ff @(posedge clka) begin
        if (!rstn) begin
            douta    <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= fin_v;
            if (fin_v) douta <= fin_d;
        end
    end

endmodule

// File: tb/tb_ram_block_be.sv
// -----------------------------------------------------------------------------
// tb_ram_block_be
//   Self-checking bench for ram_block_be. Two instances run side by side:
//     dut 0 : defaults (DEPTH 2048, OUT_REG 0, WR_MODE 0)
//     dut 1 : DEPTH 1000, OUT_REG 1, WR_MODE 1 (addresses >= 1000 are out of range)
//   Each instance has a behavioural model: an array of words, a count of
//   words still to be cleared, and a queue of results with the cycle each
//   one is due. busy, rd_valid and douta are compared every cycle. Directed
//   checks compare against constants.
// -----------------------------------------------------------------------------
module tb_ram_block_be;

    logic        clk = 1'b0;
    logic        rstn     [2];
    logic        ena      [2];
    logic [3:0]  wea      [2];
    logic [10:0] addra    [2];
    logic [31:0] dina     [2];
    logic        clr      [2];
    logic [31:0] douta    [2];
    logic        rd_valid [2];
    logic        busy     [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ram_block_be u_dut0 (
        .clka(clk), .rstn(rstn[0]), .ena(ena[0]), .wea(wea[0]),
        .addra(addra[0]), .dina(dina[0]), .clr(clr[0]),
        .douta(douta[0]), .rd_valid(rd_valid[0]), .busy(busy[0])
    );

    ram_block_be #(.DEPTH(1000), .OUT_REG(1), .WR_MODE(1)) u_dut1 (
        .clka(clk), .rstn(rstn[1]), .ena(ena[1]), .wea(wea[1]),
        .addra(addra[1]), .dina(dina[1]), .clr(clr[1]),
        .douta(douta[1]), .rd_valid(rd_valid[1]), .busy(busy[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural models, one per instance
    // ------------------------------------------------------------------
    for (genvar g = 0; g < 2; g++) begin : mdl
        localparam int DEP = (g == 0) ? 2048 : 1000;
        localparam int LAT = (g == 0) ? 1 : 2;
        localparam bit WF  = (g == 1);

        logic [31:0] mem_m [2048];
        int          clear_left = 0;
        bit          pending    = 1'b0;
        bit          started    = 1'b0;
        bit          m_valid    = 1'b0;
        logic [31:0] m_dout     = '0;
        int          ecount     = 0;
        int          due_q [$];
        logic [31:0] dat_q [$];

        initial foreach (mem_m[i]) mem_m[i] = '0;

        always @(posedge clk) begin
            int          a;
            logic [31:0] old_w, new_w, ret;
            ecount++;
            if (!rstn[g]) begin
                due_q.delete();
                dat_q.delete();
                m_valid    = 1'b0;
                m_dout     = '0;
                clear_left = 0;
                pending    = 1'b1;
                started    = 1'b1;
            end else begin
                m_valid = 1'b0;
                if (due_q.size() > 0 && due_q[0] == ecount) begin
                    m_valid = 1'b1;
                    m_dout  = dat_q[0];
                    void'(due_q.pop_front());
                    void'(dat_q.pop_front());
                end
                if (ena[g] && clear_left == 0) begin
                    a     = int'(addra[g]);
                    old_w = (a < DEP) ? mem_m[a] : 32'h0;
                    new_w = old_w;
                    for (int b = 0; b < 4; b++)
                        if (wea[g][b]) new_w[8*b +: 8] = dina[g][8*b +: 8];
                    ret = (a >= DEP) ? 32'h0 : (WF ? new_w : old_w);
                    if (a < DEP) mem_m[a] = new_w;
                    due_q.push_back(ecount + LAT);
                    dat_q.push_back(ret);
                end
                if (clear_left > 0) begin
                    mem_m[DEP - clear_left] = '0;
                    clear_left--;
                end else if (pending || clr[g]) begin
                    clear_left = DEP;
                end
                pending = 1'b0;
            end
        end

        always @(negedge clk) begin
            if (started) begin
                check($sformatf("d%0d_busy", g), 32'(busy[g]), 32'(rstn[g] && clear_left > 0));
                check($sformatf("d%0d_rd_valid", g), 32'(rd_valid[g]), 32'(m_valid));
                check($sformatf("d%0d_douta", g), douta[g], m_dout);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic access(input int d, input logic [3:0] we, input logic [10:0] a,
                          input logic [31:0] dat, input logic [31:0] exp, input string tag);
        bit          seen;
        logic [31:0] got;
        seen = 1'b0;
        got  = '0;
        @(posedge clk); #1;
        ena[d] = 1'b1; wea[d] = we; addra[d] = a; dina[d] = dat;
        @(posedge clk); #1;
        ena[d] = 1'b0; wea[d] = '0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clk);
            if (rd_valid[d]) begin
                seen = 1'b1;
                got  = douta[d];
            end
        end
        check({tag, "_vld"}, 32'(seen), 32'd1);
        check(tag, got, exp);
    endtask

    task automatic count_busy(input int d, input int exp, input string tag);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (busy[d]) cnt++;
            else if (cnt > 0) break;
        end
        check(tag, 32'(cnt), 32'(exp));
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while (busy[d] && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("idle_tmo", 32'(n < 5000), 32'd1);
    endtask

    task automatic stream_write(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            ena[d] = 1'b1; wea[d] = 4'hF; addra[d] = 11'(i); dina[d] = 32'(i);
        end
        @(posedge clk); #1;
        ena[d] = 1'b0; wea[d] = '0;
        repeat (4) @(posedge clk);
    endtask

    task automatic rand_traffic(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rstn[d] = ($urandom_range(0, 2499) != 0);
            clr[d]  = ($urandom_range(0, 1499) == 0);
            ena[d]  = ($urandom_range(0, 9) < 6);
            wea[d]  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            dina[d] = $urandom;
            case ($urandom_range(0, 3))
                0:       addra[d] = 11'($urandom_range(0, 31));
                1:       addra[d] = 11'($urandom_range(990, 1010));
                2:       addra[d] = 11'($urandom_range(1500, 1510));
                default: addra[d] = 11'($urandom_range(2040, 2047));
            endcase
        end
        @(posedge clk); #1;
        rstn[d] = 1'b1; clr[d] = 1'b0; ena[d] = 1'b0; wea[d] = '0;
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int lat;
        int vcnt;
        for (int d = 0; d < 2; d++) begin
            rstn[d] = 1'b0; ena[d] = 1'b0; wea[d] = '0;
            addra[d] = '0; dina[d] = '0; clr[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_douta", douta[0], 32'h0);
        check("rst_rd_valid", 32'(rd_valid[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        rstn[0] = 1'b1; rstn[1] = 1'b1;

        // Clear after reset release lasts exactly DEPTH cycles.
        fork
            count_busy(0, 2048, "init_busy_len0");
            count_busy(1, 1000, "init_busy_len1");
        join

        access(0, 4'h0, 11'd0,    32'h0, 32'h0, "clr_rd0");
        access(0, 4'h0, 11'd1023, 32'h0, 32'h0, "clr_rd1023");
        access(0, 4'h0, 11'd2047, 32'h0, 32'h0, "clr_rd2047");

        // Byte-enable merge (read-first returns the old word on writes).
        access(0, 4'hF, 11'd5, 32'hDEADBEEF, 32'h00000000, "be_wr1");
        access(0, 4'h5, 11'd5, 32'h11223344, 32'hDEADBEEF, "be_wr2");
        access(0, 4'h0, 11'd5, 32'h0,        32'hDE22BE44, "be_rd");

        // Read-during-write: read-first on dut 0, write-first on dut 1.
        access(0, 4'hF, 11'd9, 32'hAAAAAAAA, 32'h00000000, "rf_wr1");
        access(0, 4'hF, 11'd9, 32'h55555555, 32'hAAAAAAAA, "rf_wr2");
        access(1, 4'hF, 11'd9, 32'hAAAAAAAA, 32'hAAAAAAAA, "wf_wr1");
        access(1, 4'hF, 11'd9, 32'h55555555, 32'h55555555, "wf_wr2");
        access(1, 4'hF, 11'd5, 32'hDEADBEEF, 32'hDEADBEEF, "wf_be1");
        access(1, 4'h5, 11'd5, 32'h11223344, 32'hDE22BE44, "wf_be2");

        // Output register: two-cycle latency, fully pipelined.
        stream_write(1, 100);
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    if (i > 0) begin @(posedge clk); #1; end
                    ena[1] = 1'b1; wea[1] = 4'h0; addra[1] = 11'(i);
                end
                @(posedge clk); #1;
                ena[1] = 1'b0;
            end
            begin
                @(posedge clk);
                lat = 0;
                for (int k = 1; k <= 6 && lat == 0; k++) begin
                    @(posedge clk); #1;
                    if (rd_valid[1]) lat = k;
                end
                check("oreg_latency", 32'(lat), 32'd2);
                check("oreg_d0", douta[1], 32'd0);
                for (int i = 1; i < 100; i++) begin
                    @(posedge clk); #1;
                    check("oreg_vld", 32'(rd_valid[1]), 32'd1);
                    check("oreg_d", douta[1], 32'(i));
                end
            end
        join
        repeat (4) @(posedge clk);

        // Out-of-range address on the 1000-word instance.
        access(1, 4'hF, 11'd476,  32'hCAFEF00D, 32'hCAFEF00D, "oor_pre");
        access(1, 4'hF, 11'd1500, 32'h12345678, 32'h00000000, "oor_wr");
        access(1, 4'h0, 11'd1500, 32'h0,        32'h00000000, "oor_rd");
        access(1, 4'h0, 11'd476,  32'h0,        32'hCAFEF00D, "oor_alias");

        // Clear requested during traffic: no results while busy.
        access(0, 4'hF, 11'd0,    32'h0BADF00D, 32'h0, "pre_w0");
        access(0, 4'hF, 11'd700,  32'h12121212, 32'h0, "pre_w700");
        access(0, 4'hF, 11'd2047, 32'h34343434, 32'h0, "pre_w2047");
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (i >= 13 && rd_valid[0]) vcnt++;
            ena[0]   = 1'b1;
            wea[0]   = 4'($urandom_range(0, 15));
            addra[0] = 11'($urandom_range(0, 2047));
            dina[0]  = $urandom;
            clr[0]   = (i == 10);
        end
        @(posedge clk); #1;
        ena[0] = 1'b0; wea[0] = '0;
        check("busy_no_vld", 32'(vcnt), 32'd0);
        wait_idle(0);
        access(0, 4'h0, 11'd0,    32'h0, 32'h0, "clr2_rd0");
        access(0, 4'h0, 11'd700,  32'h0, 32'h0, "clr2_rd700");
        access(0, 4'h0, 11'd2047, 32'h0, 32'h0, "clr2_rd2047");

        // Reset at clear word 700: busy drops at once, clear restarts in full.
        access(0, 4'hF, 11'd1500, 32'h77777777, 32'h0, "pre_w1500");
        @(posedge clk); #1;
        clr[0] = 1'b1;
        @(posedge clk); #1;
        clr[0] = 1'b0;
        repeat (699) @(posedge clk);
        #1;
        rstn[0] = 1'b0;
        #1;
        check("rst_busy_now", 32'(busy[0]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn[0] = 1'b1;
        count_busy(0, 2048, "restart_busy_len");
        access(0, 4'h0, 11'd700,  32'h0, 32'h0, "rst_rd700");
        access(0, 4'h0, 11'd1500, 32'h0, 32'h0, "rst_rd1500");

        // Randomised traffic against the models.
        fork
            rand_traffic(0, 6000);
            rand_traffic(1, 6000);
        join
        repeat (6) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_block_be.md
Name: ram_block_be

Overview:
- Parametrised successor to the single-port data/instruction RAM used by the multi-cycle CPU.
- Adds per-byte write enables, an optional output register stage, a selectable read-during-write mode, and a hardware clear sequencer that zeroes memory after reset or on request.
- Sits between the CPU memory-interface FSM and storage; exposes a busy flag and a read-valid strobe, so the CPU never needs fixed-latency assumptions.

Parameters:
- DATA_W, 32: word width; must be a multiple of 8.
- ADDR_W, 11: address width.
- DEPTH, 2048: number of words; must satisfy DEPTH <= 2**ADDR_W.
- OUT_REG, 0: 0 gives 1-cycle read latency; 1 adds an output register, giving 2-cycle latency.
- WR_MODE, 0: read-during-write behaviour; 0 = read-first (old data), 1 = write-first (new merged data).
- CLEAR_ON_RESET, 1: 1 runs the clear sequence automatically when reset is released.

Ports:
- clka, input, 1: sole clock; all logic is on the rising edge.
- rstn, input, 1: synchronous active-low reset.
- ena, input, 1: access enable; a read or write happens only when ena=1 and busy=0.
- wea, input, DATA_W/8: byte write enables; bit i covers dina[8i+7:8i]; all zero means a read.
- addra, input, ADDR_W: word address.
- dina, input, DATA_W: write data.
- clr, input, 1: single-cycle request to start the clear sequence.
- douta, output, DATA_W: read data.
- rd_valid, output, 1: one-cycle strobe marking the cycle in which douta holds the result of an accepted access.
- busy, output, 1: clear sequence in progress; accesses are ignored while high.

Behaviour:
- Reset (rstn=0 at a clock edge): douta=0, rd_valid=0, pipeline registers=0, clear pointer=0.
  - busy=0 while rstn=0.
  - Memory contents are not altered by reset itself.
- FSM states: IDLE and CLEAR.
  - IDLE -> CLEAR on the first edge with rstn=1 after reset when CLEAR_ON_RESET=1, or on clr=1 while in IDLE.
  - CLEAR writes 0 to word clr_ptr each cycle, incrementing from 0 to DEPTH-1.
  - CLEAR -> IDLE on the cycle after DEPTH-1 is written. Clear takes exactly DEPTH cycles; busy=1 for all of them.
  - clr=1 while in CLEAR is ignored; the sequence does not restart.
  - rstn=0 mid-clear returns to IDLE with pointer 0. A new clear starts from word 0 after release if CLEAR_ON_RESET=1.
- Access is accepted when ena=1 and busy=0 and state=IDLE. ena is ignored while busy; no rd_valid results.
- Write (any wea bit set):
  - Only enabled bytes are updated; other bytes keep their old value.
  - An access also returns data on douta and pulses rd_valid.
  - WR_MODE=0 returns the pre-write word; WR_MODE=1 returns the merged post-write word.
- Read latency:
  - OUT_REG=0: douta and rd_valid update at edge N+1 for an access accepted at edge N.
  - OUT_REG=1: they update at edge N+2.
  - Back-to-back accesses are fully pipelined, one per cycle.
  - douta holds its last value when no access completes; rd_valid=0 in those cycles.
- Out-of-range address (addra >= DEPTH, only possible when DEPTH < 2**ADDR_W):
  - Writes are dropped.
  - Reads return 0 with rd_valid still pulsed.
- Reset mid-read-pipeline flushes pending results: no rd_valid after reset.
- The memory array must infer block RAM: a single synchronous read port, no asynchronous read.

Test Plan:
- Defaults, CLEAR_ON_RESET=1; release rstn -> busy=1 for exactly 2048 cycles. Afterwards, reads of addresses 0, 1023, and 2047 return 0x00000000.
- Write 0xDEADBEEF with wea=4'b1111 to address 5, then write 0x11223344 with wea=4'b0101 to address 5; read address 5 -> 0xDE22BE44.
- WR_MODE=0, word holds 0xAAAAAAAA; write 0x55555555 with wea=4'hF -> douta=0xAAAAAAAA next cycle. Repeat with WR_MODE=1 -> douta=0x55555555.
- OUT_REG=1; read addresses 0..99 with addra=i on consecutive cycles after writing data=i -> rd_valid rises 2 cycles after the first access. douta then steps 0, 1, ..., 99 one per cycle.
- Pulse clr during traffic with ena=1 -> no rd_valid while busy, memory all zero afterwards. Assert rstn=0 at clear word 700 -> busy=0 at once, and the clear restarts from word 0 after release.
- DEPTH=1000, ADDR_W=11: write 0x12345678 to address 1500 -> a read of 1500 returns 0 and word 1500-1024=476 stays unchanged.
